// File: rtl/ahb_lite_master_req_arbiter_pkg.sv
// Shared AHB-Lite encodings and default bus widths used by the request arbiter slice.
package ahb_lite_master_req_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

endpackage

// File: rtl/ahb_lite_master_req_arbiter_if.sv
// Request-side, completion-side and master-command signals of the AHB-Lite request arbiter.
interface ahb_lite_master_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ahb_lite_master_req_arbiter_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W  = ahb_lite_master_req_arbiter_pkg::DEFAULT_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_haddr;
  logic [NUM_REQ-1:0]        req_hwrite;
  logic [NUM_REQ*3-1:0]      req_hsize;
  logic [NUM_REQ*DATA_W-1:0] req_hwdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_write;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      HREADY;
  logic [DATA_W-1:0]         HRDATA;
  logic                      instr_available;
  logic [ADDR_W-1:0]         instr_haddr;
  logic                      instr_hwrite;
  logic [2:0]                instr_hsize;
  logic [DATA_W-1:0]         instr_hwdata;

  // Arbiter's view: takes requests and bus status, drives grants, completions and the command slot.
  modport master (
    input  req_valid, req_lock, req_haddr, req_hwrite, req_hsize, req_hwdata, HREADY, HRDATA,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
           instr_available, instr_haddr, instr_hwrite, instr_hsize, instr_hwdata
  );

  modport slave (
    output req_valid, req_lock, req_haddr, req_hwrite, req_hsize, req_hwdata, HREADY, HRDATA,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
           instr_available, instr_haddr, instr_hwrite, instr_hsize, instr_hwdata
  );
endinterface

// File: rtl/ahb_lite_master_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, or only lock_id while locked.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 lock_en,
  input  logic [$clog2(N)-1:0] lock_id,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);
  typedef logic [$clog2(N)-1:0] idx_t;

  always_comb begin
    int idx;
    // NOTE: every output gets a default first so no path through the block infers a latch.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (lock_en) begin
      if (req[lock_id]) begin
        grant[lock_id] = 1'b1;
        grant_idx      = lock_id;
        grant_valid    = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr) + i) % N;
        if (!grant_valid && req[idx]) begin
          grant[idx]  = 1'b1;
          grant_idx   = idx_t'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ahb_lite_master_req_arbiter.sv
// Shares one AHB-Lite master command slot among NUM_REQ requesters and routes completions to owners.
module ahb_lite_master_req_arbiter
  import ahb_lite_master_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  ahb_lite_master_req_arbiter_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t               ptr, lock_id, slot_owner, dphase_owner, grant_idx;
  logic               locked, dphase_valid, dphase_write;
  logic               grant_valid, accept, open;
  logic [NUM_REQ-1:0] grant;

  function automatic idx_t next_ptr(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // A low HREADY freezes the slot, the pointer and the grant, even when the slot is empty.
  assign accept = bus.instr_available & bus.HREADY;
  assign open   = !HRESET & bus.HREADY & (!bus.instr_available | accept);

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req         (bus.req_valid),
    .ptr         (ptr),
    .lock_en     (locked),
    .lock_id     (lock_id),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign bus.req_ready = grant & {NUM_REQ{open}};

  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (HRESET) begin
      bus.instr_available <= 1'b0;
      bus.instr_haddr     <= '0;
      bus.instr_hwrite    <= 1'b0;
      bus.instr_hsize     <= '0;
      bus.instr_hwdata    <= '0;
      slot_owner          <= '0;
      ptr                 <= '0;
      locked              <= 1'b0;
      lock_id             <= '0;
      dphase_valid        <= 1'b0;
      dphase_owner        <= '0;
      dphase_write        <= 1'b0;
    end else begin
      if (open) begin
        if (grant_valid) begin
          bus.instr_available <= 1'b1;
          bus.instr_haddr     <= bus.req_haddr[grant_idx*ADDR_W +: ADDR_W];
          bus.instr_hwrite    <= bus.req_hwrite[grant_idx];
          bus.instr_hsize     <= bus.req_hsize[grant_idx*3 +: 3];
          bus.instr_hwdata    <= bus.req_hwdata[grant_idx*DATA_W +: DATA_W];
          slot_owner          <= grant_idx;
          if (bus.req_lock[grant_idx]) begin
            ptr     <= grant_idx;
            locked  <= 1'b1;
            lock_id <= grant_idx;
          end else begin
            ptr    <= next_ptr(grant_idx);
            locked <= 1'b0;
          end
        end else begin
          // While locked, an empty open cycle means the lock holder withdrew its request.
          bus.instr_available <= 1'b0;
          locked              <= 1'b0;
        end
      end
      if (accept) begin
        dphase_valid <= 1'b1;
        dphase_owner <= slot_owner;
        dphase_write <= bus.instr_hwrite;
      end else if (bus.HREADY) begin
        dphase_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (!HRESET && dphase_valid && bus.HREADY) bus.rsp_valid[dphase_owner] = 1'b1;
  end

  assign bus.rsp_write = dphase_write;
  assign bus.rsp_rdata = bus.HRDATA;
endmodule

// File: tb/tb_ahb_lite_master_req_arbiter.sv
// Directed self-checking bench for the AHB-Lite master request arbiter (2 requesters).
module tb_ahb_lite_master_req_arbiter;
  import ahb_lite_master_req_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic HCLK = 1'b0;
  logic HRESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  ahb_lite_master_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_lite_master_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic [ADDR_W-1:0] a,
                         input logic wr, input logic [2:0] sz, input logic [DATA_W-1:0] wd);
    bus.req_valid[i]                    = v;
    bus.req_lock[i]                     = lk;
    bus.req_haddr[i*ADDR_W +: ADDR_W]   = a;
    bus.req_hwrite[i]                   = wr;
    bus.req_hsize[i*3 +: 3]             = sz;
    bus.req_hwdata[i*DATA_W +: DATA_W]  = wd;
  endtask

  task automatic drop_req(input int i);
    bus.req_valid[i] = 1'b0;
    bus.req_lock[i]  = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    tick(); tick();
    HRESET = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h100, 1'b0, HSIZE_WORD, '0);
    set_req(1, 1'b1, 1'b0, 32'h200, 1'b0, HSIZE_WORD, '0);
    tick(); tick();
    HRESET = 1'b1;
    settle();
    n_checks++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected %b", bus.req_ready, 2'b00);
    end
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp_suppressed: got %b expected %b", bus.rsp_valid, 2'b00);
    end
    tick(); tick(); tick();
    n_checks++;
    if (bus.instr_available !== 1'b0) begin
      n_fail++; $display("FAIL reset_instr_available: got %b expected 0", bus.instr_available);
    end
    HRESET = 1'b0;
    settle();
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_grant: got %b expected %b", bus.req_ready, 2'b01);
    end
    tick();
    n_checks++;
    if (bus.instr_available !== 1'b1 || bus.instr_haddr !== 32'h100) begin
      n_fail++; $display("FAIL reset_first_slot: got avail=%b addr=%h expected avail=1 addr=%h",
                         bus.instr_available, bus.instr_haddr, 32'h100);
    end
    drop_req(0); drop_req(1);
    tick(); tick(); tick();
    n_checks++;
    if (bus.instr_available !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_drain: got avail=%b rsp=%b expected avail=0 rsp=00",
                         bus.instr_available, bus.rsp_valid);
    end
  endtask

  task automatic test_single();
    bus.HRDATA = 32'hDEAD_BEEF;
    set_req(1, 1'b1, 1'b0, 32'h0000_0010, 1'b0, HSIZE_WORD, '0);
    settle();
    n_checks++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL single_req_ready: got %b expected %b", bus.req_ready, 2'b10);
    end
    tick();
    drop_req(1);
    settle();
    n_checks++;
    if (bus.instr_available !== 1'b1 || bus.instr_haddr !== 32'h10 ||
        bus.instr_hwrite !== 1'b0 || bus.instr_hsize !== 3'b010) begin
      n_fail++; $display("FAIL single_slot: got avail=%b addr=%h wr=%b size=%b expected 1 %h 0 010",
                         bus.instr_available, bus.instr_haddr, bus.instr_hwrite, bus.instr_hsize, 32'h10);
    end
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_no_early_rsp: got %b expected 00", bus.rsp_valid);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_rsp: got v=%b wr=%b data=%h expected v=10 wr=0 data=%h",
                         bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, 32'hDEAD_BEEF);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.instr_available !== 1'b0) begin
      n_fail++; $display("FAIL single_one_pulse: got rsp=%b avail=%b expected 00 0",
                         bus.rsp_valid, bus.instr_available);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] q0 [2]       = '{32'h4, 32'h8};
    logic [31:0] q1 [2]       = '{32'hC, 32'h10};
    logic [31:0] slot_exp [4] = '{32'h4, 32'hC, 32'h8, 32'h10};
    logic [1:0]  rsp_exp [6]  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    int i0 = 0;
    int i1 = 0;
    logic [1:0] hs;
    set_req(0, 1'b1, 1'b0, q0[0], 1'b1, HSIZE_WORD, 32'hA0);
    set_req(1, 1'b1, 1'b0, q1[0], 1'b1, HSIZE_WORD, 32'hB0);
    for (int c = 0; c < 6; c++) begin
      settle();
      hs = bus.req_ready & bus.req_valid;
      tick();
      if (hs[0]) begin
        i0++;
        if (i0 < 2) set_req(0, 1'b1, 1'b0, q0[i0], 1'b1, HSIZE_WORD, 32'hA1); else drop_req(0);
      end
      if (hs[1]) begin
        i1++;
        if (i1 < 2) set_req(1, 1'b1, 1'b0, q1[i1], 1'b1, HSIZE_WORD, 32'hB1); else drop_req(1);
      end
      settle();
      n_checks++;
      if (bus.rsp_valid !== rsp_exp[c] || (rsp_exp[c] != 2'b00 && bus.rsp_write !== 1'b1)) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b wr=%b expected v=%b wr=1",
                           c, bus.rsp_valid, bus.rsp_write, rsp_exp[c]);
      end
      if (c < 4) begin
        n_checks++;
        if (bus.instr_available !== 1'b1 || bus.instr_haddr !== slot_exp[c]) begin
          n_fail++; $display("FAIL rr_slot[%0d]: got avail=%b addr=%h expected avail=1 addr=%h",
                             c, bus.instr_available, bus.instr_haddr, slot_exp[c]);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [31:0] q0 [3]       = '{32'h20, 32'h24, 32'h28};
    logic        lk0 [3]      = '{1'b1, 1'b1, 1'b0};
    logic [31:0] slot_exp [4] = '{32'h20, 32'h24, 32'h28, 32'h30};
    logic [1:0]  rsp_exp [6]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    int i0 = 0;
    logic [1:0] hs;
    set_req(0, 1'b1, lk0[0], q0[0], 1'b1, HSIZE_WORD, 32'hC0);
    set_req(1, 1'b1, 1'b0, 32'h30, 1'b1, HSIZE_WORD, 32'hD0);
    for (int c = 0; c < 6; c++) begin
      settle();
      hs = bus.req_ready & bus.req_valid;
      tick();
      if (hs[0]) begin
        i0++;
        if (i0 < 3) set_req(0, 1'b1, lk0[i0], q0[i0], 1'b1, HSIZE_WORD, 32'hC1); else drop_req(0);
      end
      if (hs[1]) drop_req(1);
      settle();
      n_checks++;
      if (bus.rsp_valid !== rsp_exp[c]) begin
        n_fail++; $display("FAIL lock_rsp[%0d]: got %b expected %b", c, bus.rsp_valid, rsp_exp[c]);
      end
      if (c < 4) begin
        n_checks++;
        if (bus.instr_available !== 1'b1 || bus.instr_haddr !== slot_exp[c]) begin
          n_fail++; $display("FAIL lock_slot[%0d]: got avail=%b addr=%h expected avail=1 addr=%h",
                             c, bus.instr_available, bus.instr_haddr, slot_exp[c]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    bus.HRDATA = 32'h0BAD_F00D;
    set_req(0, 1'b1, 1'b0, 32'h5A5A_5A5A, 1'b1, HSIZE_WORD, 32'hAA);
    tick();
    drop_req(0);
    set_req(1, 1'b1, 1'b0, 32'h40, 1'b0, HSIZE_WORD, '0);
    bus.HREADY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++;
      if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL wait_frozen[%0d]: got ready=%b rsp=%b expected 00 00",
                           c, bus.req_ready, bus.rsp_valid);
      end
      n_checks++;
      if (bus.instr_available !== 1'b1 || bus.instr_haddr !== 32'h5A5A_5A5A ||
          bus.instr_hwdata !== 32'hAA || bus.instr_hwrite !== 1'b1) begin
        n_fail++; $display("FAIL wait_slot_stable[%0d]: got avail=%b addr=%h wdata=%h wr=%b expected 1 5a5a5a5a aa 1",
                           c, bus.instr_available, bus.instr_haddr, bus.instr_hwdata, bus.instr_hwrite);
      end
      tick();
    end
    bus.HREADY = 1'b1;
    settle();
    n_checks++;
    if (bus.req_ready !== 2'b10 || bus.rsp_valid !== 2'b00 || bus.instr_haddr !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL wait_release: got ready=%b rsp=%b addr=%h expected 10 00 5a5a5a5a",
                         bus.req_ready, bus.rsp_valid, bus.instr_haddr);
    end
    tick();
    drop_req(1);
    bus.HREADY = 1'b0;
    settle();
    n_checks++;
    if (bus.rsp_valid !== 2'b00 || bus.instr_haddr !== 32'h40) begin
      n_fail++; $display("FAIL wait_dphase_hold: got rsp=%b addr=%h expected 00 00000040",
                         bus.rsp_valid, bus.instr_haddr);
    end
    tick();
    bus.HREADY = 1'b1;
    settle();
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_write !== 1'b1) begin
      n_fail++; $display("FAIL wait_rsp0: got v=%b wr=%b expected v=01 wr=1", bus.rsp_valid, bus.rsp_write);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_write !== 1'b0 || bus.rsp_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL wait_rsp1: got v=%b wr=%b data=%h expected v=10 wr=0 data=0badf00d",
                         bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL wait_idle: got %b expected 00", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.HRDATA = 32'h1234_5678;
    set_req(0, 1'b1, 1'b0, 32'hC, 1'b0, HSIZE_WORD, '0);
    set_req(1, 1'b1, 1'b0, 32'h8, 1'b0, HSIZE_WORD, '0);
    settle();
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL b2b_first_grant: got %b expected 01", bus.req_ready);
    end
    tick();
    drop_req(0);
    settle();
    n_checks++;
    if (bus.instr_haddr !== 32'hC || bus.req_ready !== 2'b10 || bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL b2b_slot0: got addr=%h ready=%b rsp=%b expected 0000000c 10 00",
                         bus.instr_haddr, bus.req_ready, bus.rsp_valid);
    end
    tick();
    drop_req(1);
    settle();
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.instr_available !== 1'b1 || bus.instr_haddr !== 32'h8 ||
        bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_write !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overlap: got rsp=%b avail=%b addr=%h data=%h wr=%b expected 01 1 00000008 12345678 0",
                         bus.rsp_valid, bus.instr_available, bus.instr_haddr, bus.rsp_rdata, bus.rsp_write);
    end
    bus.HRDATA = 32'hCAFE_F00D;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'hCAFE_F00D || bus.instr_available !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_rsp: got rsp=%b data=%h avail=%b expected 10 cafef00d 0",
                         bus.rsp_valid, bus.rsp_rdata, bus.instr_available);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL b2b_idle: got %b expected 00", bus.rsp_valid);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET         = 1'b1;
    bus.req_valid  = '0;
    bus.req_lock   = '0;
    bus.req_haddr  = '0;
    bus.req_hwrite = '0;
    bus.req_hsize  = '0;
    bus.req_hwdata = '0;
    bus.HREADY     = 1'b1;
    bus.HRDATA     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_wait_states();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
